// File: rtl/ysyx_22040237_ifu_if.sv
// Fetch-unit bus bundle: redirect input, imem request/response channels and decode handshake.
// The master modport is the fetch unit; slave is the memory/decode/execute side.
interface ysyx_22040237_ifu_if #(
   parameter int XLEN = 64
);
   logic            pc_jump_flag_i;
   logic [XLEN-1:0] pc_jump_addr_i;
   logic            imem_req_valid_o;
   logic            imem_req_ready_i;
   logic [XLEN-1:0] imem_req_addr_o;
   logic            imem_rsp_valid_i;
   logic [31:0]     imem_rsp_data_i;
   logic            imem_rsp_err_i;
   logic            inst_valid_o;
   logic            inst_ready_i;
   logic [31:0]     inst_o;
   logic [XLEN-1:0] inst_pc_o;
   logic            inst_fault_o;

   modport master (
      input  pc_jump_flag_i, pc_jump_addr_i, imem_req_ready_i,
             imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i, inst_ready_i,
      output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o,
             inst_pc_o, inst_fault_o
   );

   modport slave (
      output pc_jump_flag_i, pc_jump_addr_i, imem_req_ready_i,
             imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i, inst_ready_i,
      input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o,
             inst_pc_o, inst_fault_o
   );
endinterface

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding imem read, result held for decode until consumed.
// All outputs are decoded from registers only.
//
//  state   | meaning
//  S_BOOT  | one idle cycle after reset
//  S_REQ   | request valid, waiting for imem to accept
//  S_WAIT  | request accepted, waiting for the response pulse
//  S_HOLD  | fetched word presented to decode
//  S_FAULT | misaligned redirect presented as a faulting nop
module ysyx_22040237_ifu #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input logic                 clk,
   input logic                 rst,
   ysyx_22040237_ifu_if.master bus
);
   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inst_pc;
   logic [31:0]     r_inst;
   logic            r_fault;
   logic            w_presenting;
   logic            w_accept;
   logic            w_bad_target;
   logic [XLEN-1:0] w_next_pc;

   assign w_presenting = (r_state == S_HOLD) || (r_state == S_FAULT);
   assign w_accept     = w_presenting && bus.inst_ready_i;
   assign w_bad_target = bus.pc_jump_flag_i && (bus.pc_jump_addr_i[1:0] != 2'b00);
   assign w_next_pc    = bus.pc_jump_flag_i ? bus.pc_jump_addr_i : r_inst_pc + XLEN'(4);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BOOT:  w_state_nxt = S_REQ;
         S_REQ:   if (bus.imem_req_ready_i) w_state_nxt = S_WAIT;
         S_WAIT:  if (bus.imem_rsp_valid_i) w_state_nxt = S_HOLD;
         S_HOLD,
         S_FAULT: if (w_accept) w_state_nxt = w_bad_target ? S_FAULT : S_REQ;
         default: w_state_nxt = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_BOOT;
      else     r_state <= w_state_nxt;
   end

   // Responses outside S_WAIT are stale (e.g. from before a reset) and ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_inst_pc <= '0;
         r_inst    <= '0;
         r_fault   <= 1'b0;
      end else if (r_state == S_WAIT && bus.imem_rsp_valid_i) begin
         r_inst    <= bus.imem_rsp_data_i;
         r_fault   <= bus.imem_rsp_err_i;
         r_inst_pc <= r_pc;
      end else if (w_accept) begin
         r_pc <= w_next_pc;
         if (w_bad_target) begin
            r_inst    <= NOP;
            r_fault   <= 1'b1;
            r_inst_pc <= bus.pc_jump_addr_i;
         end
      end
   end

   assign bus.imem_req_valid_o = (r_state == S_REQ);
   assign bus.imem_req_addr_o  = r_pc;
   assign bus.inst_valid_o     = w_presenting;
   assign bus.inst_o           = r_inst;
   assign bus.inst_pc_o        = r_inst_pc;
   assign bus.inst_fault_o     = r_fault;
endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed bench for the fetch unit; expected request addresses and presented
// instructions go through scoreboard queues filled when stimulus is driven.
module tb_ysyx_22040237_ifu;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22040237_ifu_if #(.XLEN(64)) bus ();
   ysyx_22040237_ifu dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        fault;
   } exp_t;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [63:0] req_q[$];
   exp_t        inst_q[$];
   exp_t        last_e;
   logic [63:0] cur_pc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_inst(input exp_t e);
      chk("inst_valid", bus.inst_valid_o, 1);
      chk("inst", bus.inst_o, e.inst);
      chk("inst_pc", bus.inst_pc_o, e.pc);
      chk("inst_fault", bus.inst_fault_o, e.fault);
      last_e = e;
   endtask

   task automatic req_phase(input int rdy_delay);
      int t;
      logic [63:0] a;
      t = 0;
      while (bus.imem_req_valid_o !== 1'b1 && t < 20) begin
         step();
         t++;
      end
      chk("req_timeout", 64'(t < 20), 1);
      a = req_q.pop_front();
      chk("req_addr", bus.imem_req_addr_o, a);
      repeat (rdy_delay) begin
         step();
         chk("req_valid_hold", bus.imem_req_valid_o, 1);
         chk("req_addr_hold", bus.imem_req_addr_o, a);
      end
      bus.imem_req_ready_i = 1'b1;
      step();
      bus.imem_req_ready_i = 1'b0;
      chk("req_drop_after_accept", bus.imem_req_valid_o, 0);
      cur_pc = a;
   endtask

   task automatic rsp_phase(input logic [31:0] data, input logic err, input logic noise_jump);
      exp_t e;
      if (noise_jump) begin
         bus.pc_jump_flag_i = 1'b1;
         bus.pc_jump_addr_i = 64'h0000_0000_8000_0ABC;
         step();
         chk("no_req_in_wait", bus.imem_req_valid_o, 0);
         bus.pc_jump_flag_i = 1'b0;
         bus.pc_jump_addr_i = '0;
      end
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = data;
      bus.imem_rsp_err_i   = err;
      inst_q.push_back('{inst: data, pc: cur_pc, fault: err});
      step();
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
      bus.imem_rsp_err_i   = 1'b0;
      e = inst_q.pop_front();
      check_inst(e);
   endtask

   task automatic accept(input int hold, input logic jmp, input logic [63:0] ja);
      logic [63:0] nxt;
      logic        bad;
      exp_t        e;
      repeat (hold) begin
         step();
         chk("hold_valid", bus.inst_valid_o, 1);
         chk("hold_inst", bus.inst_o, last_e.inst);
         chk("hold_pc", bus.inst_pc_o, last_e.pc);
         chk("hold_fault", bus.inst_fault_o, last_e.fault);
         chk("hold_no_req", bus.imem_req_valid_o, 0);
      end
      nxt = jmp ? ja : cur_pc + 64'd4;
      bad = jmp && (ja[1:0] != 2'b00);
      if (bad) inst_q.push_back('{inst: 32'h0000_0013, pc: ja, fault: 1'b1});
      else     req_q.push_back(nxt);
      bus.inst_ready_i   = 1'b1;
      bus.pc_jump_flag_i = jmp;
      bus.pc_jump_addr_i = ja;
      step();
      bus.inst_ready_i   = 1'b0;
      bus.pc_jump_flag_i = 1'b0;
      bus.pc_jump_addr_i = '0;
      if (bad) begin
         e = inst_q.pop_front();
         check_inst(e);
         chk("fault_no_req", bus.imem_req_valid_o, 0);
         cur_pc = ja;
      end else begin
         chk("req_latency", bus.imem_req_valid_o, 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.pc_jump_flag_i   = 1'b0;
      bus.pc_jump_addr_i   = '0;
      bus.imem_req_ready_i = 1'b0;
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
      bus.imem_rsp_err_i   = 1'b0;
      bus.inst_ready_i     = 1'b0;
      cur_pc = '0;
      rst = 1'b1;
      step();
      step();
      chk("rst_req_valid", bus.imem_req_valid_o, 0);
      chk("rst_req_addr", bus.imem_req_addr_o, 64'h8000_0000);
      chk("rst_inst_valid", bus.inst_valid_o, 0);
      chk("rst_inst", bus.inst_o, 0);
      chk("rst_inst_pc", bus.inst_pc_o, 0);
      chk("rst_inst_fault", bus.inst_fault_o, 0);
      rst = 1'b0;
      chk("boot_no_req", bus.imem_req_valid_o, 0);

      // first fetch after reset
      req_q.push_back(64'h8000_0000);
      req_phase(0);
      rsp_phase(32'h0000_0093, 1'b0, 1'b0);

      // sequential advance, ignored jump while not presenting, taken redirect
      accept(0, 1'b0, '0);
      req_phase(0);
      rsp_phase(32'h0010_0113, 1'b0, 1'b1);
      accept(0, 1'b1, 64'h8000_0100);
      req_phase(0);
      rsp_phase(32'h0020_0193, 1'b0, 1'b0);

      // request backpressure, then decode backpressure
      accept(0, 1'b0, '0);
      req_phase(5);
      rsp_phase(32'h0030_0213, 1'b0, 1'b0);
      accept(4, 1'b0, '0);

      // access fault on response still advances by 4
      req_phase(0);
      rsp_phase(32'hDEAD_BEEF, 1'b1, 1'b0);
      accept(1, 1'b0, '0);
      req_phase(0);
      rsp_phase(32'h0040_0293, 1'b0, 1'b0);

      // misaligned redirects, including one taken from FAULT
      accept(0, 1'b1, 64'h8000_0102);
      accept(2, 1'b1, 64'h8000_0201);
      accept(1, 1'b1, 64'h8000_0200);
      req_phase(0);
      rsp_phase(32'h0050_0313, 1'b0, 1'b0);

      // PC wraps at the top of the address space
      accept(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      req_phase(0);
      rsp_phase(32'h0060_0393, 1'b0, 1'b0);
      accept(0, 1'b0, '0);
      req_phase(0);

      // reset while waiting; stale responses in BOOT and REQ are dropped
      rst = 1'b1;
      #1;
      chk("midrst_req_addr", bus.imem_req_addr_o, 64'h8000_0000);
      chk("midrst_req_valid", bus.imem_req_valid_o, 0);
      chk("midrst_inst_valid", bus.inst_valid_o, 0);
      step();
      rst = 1'b0;
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = 32'hBAD0_0001;
      step();
      chk("stale_boot_inst_valid", bus.inst_valid_o, 0);
      chk("stale_boot_req_valid", bus.imem_req_valid_o, 1);
      step();
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
      chk("stale_req_inst_valid", bus.inst_valid_o, 0);
      chk("stale_req_req_valid", bus.imem_req_valid_o, 1);
      req_q.push_back(64'h8000_0000);
      req_phase(0);
      rsp_phase(32'h0070_0413, 1'b0, 1'b0);
      accept(0, 1'b0, '0);
      req_phase(0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
